// File: rtl/alu_status_reg_if.sv
// Signal bundle between the CPU core (master) and the processor status register (slave).
interface alu_status_reg_if;
  logic       ce;
  logic       sync;
  logic [7:0] alu_res;
  logic       alu_c;
  logic       alu_v;
  logic [7:0] db_in;
  logic       upd_nz;
  logic       upd_c;
  logic       upd_v;
  logic       bit_ld;
  logic       p_ld;
  logic       set_c;
  logic       clr_c;
  logic       set_i;
  logic       clr_i;
  logic       set_d;
  logic       clr_d;
  logic       clr_v;
  logic       brk_push;
  logic [7:0] p_out;
  logic [7:0] p_push;
  logic       c_flag;
  logic       irq_mask;

  modport master (
    output ce, sync, alu_res, alu_c, alu_v, db_in,
    output upd_nz, upd_c, upd_v, bit_ld, p_ld,
    output set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v, brk_push,
    input  p_out, p_push, c_flag, irq_mask
  );

  modport slave (
    input  ce, sync, alu_res, alu_c, alu_v, db_in,
    input  upd_nz, upd_c, upd_v, bit_ld, p_ld,
    input  set_c, clr_c, set_i, clr_i, set_d, clr_d, clr_v, brk_push,
    output p_out, p_push, c_flag, irq_mask
  );
endinterface

// File: rtl/alu_status_reg.sv
// 6502/2A03 processor status register (N V - B D I Z C) fed by the ALU and data bus.
// Optional macro IRQ_MASK_DELAY_EN: irq_mask follows I only at instruction boundaries (sync).
module alu_status_reg #(
  parameter logic [7:0] P_RESET = 8'h34
) (
  input  logic              clk,
  input  logic              rst_n,
  alu_status_reg_if.slave   bus
);

  logic n_q, v_q, d_q, i_q, z_q, c_q;
  logic n_d, v_d, d_d, i_d, z_d, c_d;
  logic res_zero;

  assign res_zero = (bus.alu_res == 8'h00);

  always_comb begin
    n_d = n_q;
    v_d = v_q;
    d_d = d_q;
    i_d = i_q;
    z_d = z_q;
    c_d = c_q;
    if (bus.p_ld) begin
      n_d = bus.db_in[7];
      v_d = bus.db_in[6];
      d_d = bus.db_in[3];
      i_d = bus.db_in[2];
      z_d = bus.db_in[1];
      c_d = bus.db_in[0];
    end else begin
      if (bus.bit_ld)      n_d = bus.db_in[7];
      else if (bus.upd_nz) n_d = bus.alu_res[7];

      if (bus.bit_ld || bus.upd_nz) z_d = res_zero;

      // Explicit clear beats BIT, which beats the ALU overflow.
      if (bus.clr_v)       v_d = 1'b0;
      else if (bus.bit_ld) v_d = bus.db_in[6];
      else if (bus.upd_v)  v_d = bus.alu_v;

      if (bus.clr_c)       c_d = 1'b0;
      else if (bus.set_c)  c_d = 1'b1;
      else if (bus.upd_c)  c_d = bus.alu_c;

      if (bus.clr_i)       i_d = 1'b0;
      else if (bus.set_i)  i_d = 1'b1;

      if (bus.clr_d)       d_d = 1'b0;
      else if (bus.set_d)  d_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      n_q <= P_RESET[7];
      v_q <= P_RESET[6];
      d_q <= P_RESET[3];
      i_q <= P_RESET[2];
      z_q <= P_RESET[1];
      c_q <= P_RESET[0];
    end else if (bus.ce) begin
      n_q <= n_d;
      v_q <= v_d;
      d_q <= d_d;
      i_q <= i_d;
      z_q <= z_d;
      c_q <= c_d;
    end
  end

`ifdef IRQ_MASK_DELAY_EN
  logic irq_mask_q;

  // Uses next I so an I change on a sync cycle lands in the same edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      irq_mask_q <= P_RESET[2];
    end else if (bus.ce && bus.sync) begin
      irq_mask_q <= i_d;
    end
  end

  assign bus.irq_mask = irq_mask_q;
`else
  logic unused_sync;
  assign unused_sync  = bus.sync;
  assign bus.irq_mask = i_q;
`endif

  assign bus.p_out  = {n_q, v_q, 1'b1, 1'b1,         d_q, i_q, z_q, c_q};
  assign bus.p_push = {n_q, v_q, 1'b1, bus.brk_push, d_q, i_q, z_q, c_q};
  assign bus.c_flag = c_q;

endmodule

// File: tb/tb_alu_status_reg.sv
// Directed-vector bench for alu_status_reg.
module tb_alu_status_reg;
  logic clk;
  logic rst_n;
  int   total;
  int   bad;

  alu_status_reg_if bus ();

  alu_status_reg #(.P_RESET(8'h34)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_strobes();
    bus.ce       = 1'b1;
    bus.sync     = 1'b0;
    bus.alu_res  = 8'h01;
    bus.alu_c    = 1'b0;
    bus.alu_v    = 1'b0;
    bus.db_in    = 8'h00;
    bus.upd_nz   = 1'b0;
    bus.upd_c    = 1'b0;
    bus.upd_v    = 1'b0;
    bus.bit_ld   = 1'b0;
    bus.p_ld     = 1'b0;
    bus.set_c    = 1'b0;
    bus.clr_c    = 1'b0;
    bus.set_i    = 1'b0;
    bus.clr_i    = 1'b0;
    bus.set_d    = 1'b0;
    bus.clr_d    = 1'b0;
    bus.clr_v    = 1'b0;
    bus.brk_push = 1'b0;
  endtask

  // Apply current inputs across one rising edge, then clear strobes.
  task automatic tick();
    @(posedge clk);
    #1;
    clear_strobes();
  endtask

  task automatic test_reset();
    clear_strobes();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    tick();
    total++; if (bus.p_out !== 8'h34) begin bad++; $display("FAIL reset_p_out got=%h exp=34", bus.p_out); end
    bus.brk_push = 1'b0; #1;
    total++; if (bus.p_push !== 8'h24) begin bad++; $display("FAIL reset_push_b0 got=%h exp=24", bus.p_push); end
    bus.brk_push = 1'b1; #1;
    total++; if (bus.p_push !== 8'h34) begin bad++; $display("FAIL reset_push_b1 got=%h exp=34", bus.p_push); end
    bus.brk_push = 1'b0;
    total++; if (bus.c_flag !== 1'b0) begin bad++; $display("FAIL reset_c_flag got=%b exp=0", bus.c_flag); end
    total++; if (bus.irq_mask !== 1'b1) begin bad++; $display("FAIL reset_irq_mask got=%b exp=1", bus.irq_mask); end
  endtask

  task automatic test_set_clr();
    bus.set_c = 1'b1; bus.set_d = 1'b1;
    tick();
    total++; if (bus.p_out !== 8'h3D) begin bad++; $display("FAIL sec_sed got=%h exp=3D", bus.p_out); end
    bus.set_d = 1'b1; bus.clr_d = 1'b1; bus.upd_c = 1'b1; bus.alu_c = 1'b0; bus.set_c = 1'b1;
    tick();
    total++; if (bus.p_out !== 8'h35) begin bad++; $display("FAIL cld_wins_setc_over_updc got=%h exp=35", bus.p_out); end
    bus.clr_c = 1'b1; bus.upd_c = 1'b1; bus.alu_c = 1'b1;
    tick();
    total++; if (bus.p_out !== 8'h34) begin bad++; $display("FAIL clc_over_updc got=%h exp=34", bus.p_out); end
  endtask

  task automatic test_alu_update();
    bus.upd_nz = 1'b1; bus.upd_c = 1'b1; bus.upd_v = 1'b1;
    bus.alu_res = 8'h00; bus.alu_c = 1'b1; bus.alu_v = 1'b1;
    tick();
    total++; if (bus.p_out !== 8'h77) begin bad++; $display("FAIL alu_all got=%h exp=77", bus.p_out); end
    total++; if (bus.c_flag !== 1'b1) begin bad++; $display("FAIL alu_c_flag got=%b exp=1", bus.c_flag); end
    bus.upd_nz = 1'b1; bus.alu_res = 8'h80;
    tick();
    total++; if (bus.p_out !== 8'hF5) begin bad++; $display("FAIL alu_nz_only got=%h exp=F5", bus.p_out); end
  endtask

  task automatic test_p_ld();
    bus.p_ld = 1'b1; bus.db_in = 8'hFF;
    bus.clr_c = 1'b1; bus.clr_i = 1'b1; bus.clr_d = 1'b1; bus.clr_v = 1'b1;
    bus.upd_nz = 1'b1; bus.alu_res = 8'h01;
    tick();
    total++; if (bus.p_out !== 8'hFF) begin bad++; $display("FAIL p_ld_ff got=%h exp=FF", bus.p_out); end
    bus.set_c = 1'b1; bus.clr_c = 1'b1;
    tick();
    total++; if (bus.p_out !== 8'hFE) begin bad++; $display("FAIL setc_clrc got=%h exp=FE", bus.p_out); end
    bus.p_ld = 1'b1; bus.db_in = 8'h00;
    tick();
    total++; if (bus.p_out !== 8'h30) begin bad++; $display("FAIL p_ld_00 got=%h exp=30", bus.p_out); end
    bus.p_ld = 1'b1; bus.db_in = 8'hFE;
    tick();
  endtask

  task automatic test_bit();
    bus.bit_ld = 1'b1; bus.db_in = 8'h40; bus.alu_res = 8'h00;
    bus.upd_v = 1'b1; bus.alu_v = 1'b0; bus.upd_nz = 1'b1;
    tick();
    total++; if (bus.p_out !== 8'h7E) begin bad++; $display("FAIL bit_ld got=%h exp=7E", bus.p_out); end
    bus.bit_ld = 1'b1; bus.db_in = 8'h40; bus.alu_res = 8'h00; bus.clr_v = 1'b1;
    tick();
    total++; if (bus.p_out !== 8'h3E) begin bad++; $display("FAIL bit_clrv got=%h exp=3E", bus.p_out); end
  endtask

  task automatic test_irq_mask();
    logic exp_early;
`ifdef IRQ_MASK_DELAY_EN
    exp_early = 1'b1;
`else
    exp_early = 1'b0;
`endif
    bus.clr_i = 1'b1;
    tick();
    total++; if (bus.p_out !== 8'h3A) begin bad++; $display("FAIL cli_p_out got=%h exp=3A", bus.p_out); end
    total++; if (bus.irq_mask !== exp_early) begin bad++; $display("FAIL irq_k1 got=%b exp=%b", bus.irq_mask, exp_early); end
    tick();
    total++; if (bus.irq_mask !== exp_early) begin bad++; $display("FAIL irq_k2 got=%b exp=%b", bus.irq_mask, exp_early); end
    total++; if (bus.irq_mask !== exp_early) begin bad++; $display("FAIL irq_k3 got=%b exp=%b", bus.irq_mask, exp_early); end
    bus.sync = 1'b1;
    tick();
    total++; if (bus.irq_mask !== 1'b0) begin bad++; $display("FAIL irq_k4 got=%b exp=0", bus.irq_mask); end
    bus.set_i = 1'b1; bus.sync = 1'b1;
    tick();
    total++; if (bus.irq_mask !== 1'b1) begin bad++; $display("FAIL sei_on_sync got=%b exp=1", bus.irq_mask); end
    bus.clr_i = 1'b1;
    tick();
  endtask

  task automatic test_ce_and_async_reset();
    bus.ce = 1'b0; bus.upd_c = 1'b1; bus.alu_c = 1'b1; bus.set_d = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.p_out !== 8'h3A) begin bad++; $display("FAIL ce_low_hold got=%h exp=3A", bus.p_out); end
    @(negedge clk); #2;
    rst_n = 1'b0;
    #1;
    total++; if (bus.p_out !== 8'h34) begin bad++; $display("FAIL async_reset got=%h exp=34", bus.p_out); end
    total++; if (bus.irq_mask !== 1'b1) begin bad++; $display("FAIL async_reset_irq got=%b exp=1", bus.irq_mask); end
    total++; if (bus.c_flag !== 1'b0) begin bad++; $display("FAIL async_reset_c got=%b exp=0", bus.c_flag); end
    bus.ce = 1'b1;
    @(posedge clk); #1;
    total++; if (bus.p_out !== 8'h34) begin bad++; $display("FAIL reset_held got=%h exp=34", bus.p_out); end
    rst_n = 1'b1;
    clear_strobes();
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst_n = 1'b1;
    clear_strobes();
    test_reset();
    test_set_clr();
    test_alu_update();
    test_p_ld();
    test_bit();
    test_irq_mask();
    test_ce_and_async_reset();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
